drlp_img_bf_pp: RTL
===================

Name: drlp_img_bf_pp

Overview:
Parametrised ping-pong image buffer; successor to the single-bank image buffer.
- Two banks of DEPTH words; each word is LANES pixels of DATA_WIDTH bits.
- The loader (DMA side) fills one bank while the PE array reads the other.
- Bank ownership is handed over with explicit done/ready handshakes.
- Reads are truly synchronous: registered data with a valid flag.

Parameters:
DATA_WIDTH, 8, bits per pixel
LANES, 6, pixels per word; word width W = DATA_WIDTH*LANES
ADDR_WIDTH, 12, word address width; DEPTH = 2**ADDR_WIDTH per bank

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_wr_en  in  1  write strobe into current write bank
i_wr_addr  in  ADDR_WIDTH  write word address
i_wr_data  in  W  write word
i_wr_done  in  1  pulse: current write bank complete, hand to reader
o_wr_ready  out  1  current write bank is EMPTY/FILLING, writes accepted
i_rd_en  in  1  read strobe from current read bank
i_rd_addr  in  ADDR_WIDTH  read word address
i_rd_done  in  1  pulse: reader finished with current read bank, release it
o_rd_ready  out  1  current read bank is FULL, reads accepted
o_rd_data  out  W  registered read word
o_rd_valid  out  1  o_rd_data updated this cycle
o_wr_bank  out  1  index of current write bank
o_rd_bank  out  1  index of current read bank

Behaviour:
- Reset (async assert, sync release to i_clk):
  - both banks EMPTY; wr_sel=0, rd_sel=0.
  - o_rd_data=0, o_rd_valid=0, o_wr_ready=1, o_rd_ready=0.
  - Memory contents are not reset.
- Per-bank state, 1 bit: EMPTY (writer owns) or FULL (reader owns).
- o_wr_ready = (bank[wr_sel]==EMPTY); o_rd_ready = (bank[rd_sel]==FULL).
- Write path:
  - i_wr_en & o_wr_ready: mem[wr_sel][i_wr_addr] <= i_wr_data at the clock edge.
  - i_wr_en & !o_wr_ready: write dropped.
- Write handover: i_wr_done & o_wr_ready sets bank[wr_sel]=FULL and toggles wr_sel. Ignored when !o_wr_ready.
- Read path:
  - i_rd_en & o_rd_ready: o_rd_data <= mem[rd_sel][i_rd_addr] and o_rd_valid <= 1 on the next edge. Latency is exactly 1 cycle.
  - Otherwise o_rd_valid <= 0 and o_rd_data holds its last value.
- Read handover: i_rd_done & o_rd_ready sets bank[rd_sel]=EMPTY and toggles rd_sel. Ignored when !o_rd_ready.
  - A read issued in the same cycle as i_rd_done still completes; its data returns the next cycle.
- Simultaneous handovers: i_wr_done and i_rd_done in the same cycle are both applied.
  - Each affects only its own bank and its own select.
  - Example: wr_sel=1, rd_sel=0, both done → bank1 FULL, bank0 EMPTY, wr_sel=0, rd_sel=1.
- Same bank, same address: cannot occur, because one bank is never both EMPTY and FULL. No read-during-write hazard exists.
- Reset mid-operation: all state returns to the reset values. A pending o_rd_valid is cleared immediately (async). Partially written bank data is discarded logically.
- Addresses wrap implicitly modulo DEPTH; there is no range check.

Optional Feature:
DRLP_IMG_BF_ERR_EN
- With the macro: extra output o_err, 2 bits, sticky, cleared only by i_rst.
  - bit0 is set by i_wr_en or i_wr_done while !o_wr_ready (overflow).
  - bit1 is set by i_rd_en or i_rd_done while !o_rd_ready (underflow).
  - The flag is set on the cycle after the offending strobe.
- Without the macro: port absent; illegal strobes are silently ignored as described above.

Decomposition:
- Package drlp_img_bf_pkg:
  - localparams for bank states BANK_EMPTY=1'b0, BANK_FULL=1'b1.
  - typedef for the bank index.
  - error-bit position constants.
- Sub-module drlp_img_bf_bank:
  - single-bank 1W1R synchronous RAM of DEPTH x W with write enable and a registered read enable.
  - instantiated twice.
  - all handshake and select logic stays in the top level.

Test Plan:
- Reset then idle → o_wr_ready=1, o_rd_ready=0, o_rd_valid=0, o_wr_bank=0, o_rd_bank=0.
- Fill bank0: addr0..3 = 0x010203040506+k, then i_wr_done → o_rd_ready=1, o_wr_bank=1. Read addr2 → next cycle o_rd_valid=1, o_rd_data=0x010203040508.
- Ping-pong:
  - while reading bank0, fill bank1 with 0xAA.. words; pulse i_rd_done and i_wr_done in the same cycle.
  - → o_rd_bank=1, o_wr_bank=0, o_wr_ready=1.
  - reads return the 0xAA.. data.
- Both banks FULL:
  - → o_wr_ready=0; i_wr_en to addr0 with 0xFF.. is dropped, and the later read of addr0 returns the original data.
  - with ERR_EN, o_err=2'b01.
- i_rd_en with o_rd_ready=0 → o_rd_valid stays 0, o_rd_data unchanged; with ERR_EN, o_err[1]=1.
- Assert i_rst while o_rd_valid=1 mid-drain → o_rd_valid=0 asynchronously; after release both banks are EMPTY and o_wr_bank=0.

Source files
------------

// File: rtl/drlp_img_bf_pkg.sv
// Shared constants and types for the ping-pong image buffer.
package drlp_img_bf_pkg;

    localparam logic BANK_EMPTY = 1'b0;
    localparam logic BANK_FULL  = 1'b1;

    typedef logic bank_idx_t;

    localparam int unsigned ERR_W       = 2;
    localparam int unsigned ERR_OVF_BIT = 0;
    localparam int unsigned ERR_UDF_BIT = 1;

endpackage

// File: rtl/drlp_img_bf_bank.sv
// Single-bank 1W1R synchronous RAM; read data is registered and held between reads.
module drlp_img_bf_bank #(
    parameter int unsigned W          = 48,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [W-1:0]          i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [W-1:0]          o_rd_data
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // Storage array carries no reset so it can map onto a RAM macro.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/drlp_img_bf_pp.sv
// Ping-pong image buffer: loader fills one bank while the PE array drains the other.
// Optional sticky overflow/underflow flags on o_err when DRLP_IMG_BF_ERR_EN is defined.
module drlp_img_bf_pp
    import drlp_img_bf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 6,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [ADDR_WIDTH-1:0]       i_wr_addr,
    input  logic [DATA_WIDTH*LANES-1:0] i_wr_data,
    input  logic                        i_wr_done,
    output logic                        o_wr_ready,
    input  logic                        i_rd_en,
    input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
    input  logic                        i_rd_done,
    output logic                        o_rd_ready,
    output logic [DATA_WIDTH*LANES-1:0] o_rd_data,
    output logic                        o_rd_valid,
    output logic                        o_wr_bank,
    output logic                        o_rd_bank
`ifdef DRLP_IMG_BF_ERR_EN
    ,
    output logic [ERR_W-1:0]            o_err
`endif
);

    localparam int unsigned W = DATA_WIDTH * LANES;

    logic [1:0] bank_q,     bank_d;
    bank_idx_t  wr_sel_q,   wr_sel_d;
    bank_idx_t  rd_sel_q,   rd_sel_d;
    bank_idx_t  last_rd_q,  last_rd_d;
    logic       rd_valid_q, rd_valid_d;

    logic wr_ready;
    logic rd_ready;
    logic wr_fire;
    logic rd_fire;

    logic [1:0]   bank_we;
    logic [1:0]   bank_re;
    logic [W-1:0] bank_rdata [2];

    assign wr_ready = (bank_q[wr_sel_q] == BANK_EMPTY);
    assign rd_ready = (bank_q[rd_sel_q] == BANK_FULL);
    assign wr_fire  = i_wr_en & wr_ready;
    assign rd_fire  = i_rd_en & rd_ready;

    // Both handovers may fire together; they always target different banks.
    always_comb begin
        bank_d     = bank_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        last_rd_d  = last_rd_q;
        rd_valid_d = rd_fire;
        if (i_wr_done && wr_ready) begin
            bank_d[wr_sel_q] = BANK_FULL;
            wr_sel_d         = ~wr_sel_q;
        end
        if (i_rd_done && rd_ready) begin
            bank_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d         = ~rd_sel_q;
        end
        if (rd_fire) begin
            last_rd_d = rd_sel_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_q     <= {BANK_EMPTY, BANK_EMPTY};
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            last_rd_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            last_rd_q  <= last_rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = wr_fire & (wr_sel_q == bank_idx_t'(b));
        assign bank_re[b] = rd_fire & (rd_sel_q == bank_idx_t'(b));

        drlp_img_bf_bank #(
            .W          (W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (bank_we[b]),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .i_rd_en   (bank_re[b]),
            .i_rd_addr (i_rd_addr),
            .o_rd_data (bank_rdata[b])
        );
    end

    // Each bank holds its own last read word, so steering by the last-read bank holds data.
    assign o_rd_data  = bank_rdata[last_rd_q];
    assign o_rd_valid = rd_valid_q;
    assign o_wr_ready = wr_ready;
    assign o_rd_ready = rd_ready;
    assign o_wr_bank  = wr_sel_q;
    assign o_rd_bank  = rd_sel_q;

`ifdef DRLP_IMG_BF_ERR_EN
    logic [ERR_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((i_wr_en || i_wr_done) && !wr_ready) begin
            err_d[ERR_OVF_BIT] = 1'b1;
        end
        if ((i_rd_en || i_rd_done) && !rd_ready) begin
            err_d[ERR_UDF_BIT] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`endif

endmodule
